pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush controller for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
//  - Detects RAW hazards between ID source registers and the EXE/MEM destinations.
//  - Squashes wrong-path instructions on a taken branch.
//  - Sequences multi-cycle data-memory accesses with a wait-state FSM.
//  - Drives the freeze/flush inputs of the IF/ID, ID/EXE, EXE/MEM and MEM/WB registers.
// PARAMETERS
//  MEM_LAT   4   data-memory access latency in cycles (legal range 2..15)
//  FWD_EN    0   1 = forwarding unit present: only load-use vs EXE stalls; 0 = full RAW check
//  CNT_W     16  width of the hazard-stall performance counter
// PORTS
//  clk            in   1      clock
//  rst            in   1      reset (synchronous, active-high)
//  id_valid       in   1      ID stage holds a real instruction
//  id_src1        in   4      ID source register Rn
//  id_src2        in   4      ID source register Rm/Rd (store)
//  id_use_src1    in   1      instruction reads src1
//  id_two_src     in   1      instruction reads src2
//  exe_dest       in   4      destination register in EXE
//  exe_wb_en      in   1      EXE instruction writes back
//  exe_mem_r_en   in   1      EXE instruction is a load
//  mem_dest       in   4      destination register in MEM
//  mem_wb_en      in   1      MEM instruction writes back
//  branch_taken   in   1      EXE resolved a taken branch
//  mem_req        in   1      MEM stage requests a load or store
//  freeze_pc      out  1      hold PC and IF/ID register
//  flush_if_id    out  1      clear IF/ID to a bubble
//  flush_id_exe   out  1      clear ID/EXE (drives that register's flush input)
//  mem_stall      out  1      hold EXE/MEM and MEM/WB; also hold PC, IF/ID, ID/EXE
//  mem_done       out  1      one-cycle pulse: access complete, MEM data valid
//  stall_cnt      out  CNT_W  saturating count of hazard-stall cycles
// BEHAVIOUR
//  - Hazard detection (combinational):
//    - m1 = id_use_src1 & (id_src1 == d); m2 = id_two_src & (id_src2 == d).
//    - FWD_EN=0: hazard = id_valid & ((exe_wb_en & (m1|m2) for d=exe_dest)
//      | (mem_wb_en & (m1|m2) for d=mem_dest)).
//    - FWD_EN=1: hazard = id_valid & exe_mem_r_en & exe_wb_en & (m1|m2) for d=exe_dest.
//  - Memory FSM states: IDLE, ACCESS, DONE.
//    - IDLE:   mem_req -> ACCESS, cnt <= MEM_LAT-2.
//    - ACCESS: cnt==0 -> DONE, else cnt--.
//    - DONE:   -> IDLE unconditionally. mem_req in DONE belongs to the outgoing instruction and is ignored.
//  - mem_stall = (IDLE & mem_req) | ACCESS. The stall lasts exactly MEM_LAT cycles from the first cycle
//    the request is seen; the DONE cycle has mem_stall=0 and mem_done=1.
//  - Back-to-back requests: the next request is accepted in the IDLE cycle after DONE.
//  - Priority (highest first):
//    1. mem_stall: freeze_pc=1; flush_if_id=0 and flush_id_exe=0. Branch/hazard actions are deferred
//       because the branch stays held in EXE.
//    2. branch_taken: flush_if_id=1, flush_id_exe=1, freeze_pc=0. The branch overrides a
//       simultaneous hazard.
//    3. hazard: freeze_pc=1, flush_id_exe=1 (bubble inserted), flush_if_id=0.
//    4. Otherwise all outputs 0.
//  - stall_cnt increments on every clock edge where rule 3 is active. It saturates at all-ones.
//  - Reset:
//    - All outputs are forced 0 while rst=1, regardless of inputs.
//    - Next state: FSM IDLE, cnt=0, stall_cnt=0.
//    - rst mid-ACCESS aborts the access: no mem_done pulse; mem_stall=0 in the cycle after rst deasserts
//      unless mem_req is high.
// TESTING
//  1. Reset: assert rst with mem_req=1 and branch_taken=1 -> all outputs 0, stall_cnt=0.
//  2. FWD_EN=0 RAW: exe_dest=3, exe_wb_en=1, id_src1=3, id_use_src1=1 -> freeze_pc=1, flush_id_exe=1,
//     stall_cnt 0->1; the same match on mem_dest also stalls; src match with wb_en=0 -> no stall.
//  3. FWD_EN=1 load-use: hazard with exe_mem_r_en=1 stalls; the same hazard with exe_mem_r_en=0 does not.
//  4. MEM_LAT=4: hold mem_req -> mem_stall=1 for exactly 4 cycles, then mem_done=1 for 1 cycle.
//     Held request: the new access starts one cycle later.
//  5. Branch during memory stall: branch_taken=1 held across the 4-cycle stall -> flush_if_id=0 during
//     the stall, =1 in the DONE cycle. Branch plus hazard in the same cycle -> freeze_pc=0.
//  6. rst in the 2nd ACCESS cycle -> next cycle IDLE, no mem_done. stall_cnt saturation with CNT_W=2:
//     5 hazard cycles -> stall_cnt=3.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush controller for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
// Combines RAW hazard detection, taken-branch squashing and a wait-state
// sequencer for multi-cycle data-memory accesses into the freeze/flush
// controls of the pipeline registers.
//
// Memory FSM
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | no access in flight; a mem_req here starts one and stalls
//   S_ACCESS | access in flight; cnt counts the remaining stall cycles
//   S_DONE   | one-cycle completion: MEM data valid, stall released
module pipeline_hazard_ctrl #(
  parameter int MEM_LAT = 4,
  parameter int FWD_EN  = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_use_src1,
  input  logic             id_two_src,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  output logic             freeze_pc,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             mem_stall,
  output logic             mem_done,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } mem_state_t;

  // The IDLE cycle that accepts the request is the first stall cycle, so the
  // ACCESS countdown covers the remaining MEM_LAT-1 cycles (MEM_LAT-2 down to 0).
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 2);

  mem_state_t       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             stall_raw, done_raw;
  logic             hazard;
  logic             hazard_stall;
  logic [CNT_W-1:0] stall_cnt_q;

  logic m1_exe, m2_exe, m1_mem, m2_mem;

  assign m1_exe = id_use_src1 & (id_src1 == exe_dest);
  assign m2_exe = id_two_src  & (id_src2 == exe_dest);
  assign m1_mem = id_use_src1 & (id_src1 == mem_dest);
  assign m2_mem = id_two_src  & (id_src2 == mem_dest);

  // RAW detection: with forwarding only a load in EXE cannot be bypassed.
  always_comb begin
    hazard = 1'b0;
    if (FWD_EN != 0) begin
      hazard = id_valid & exe_mem_r_en & exe_wb_en & (m1_exe | m2_exe);
    end else begin
      hazard = id_valid & ((exe_wb_en & (m1_exe | m2_exe)) |
                           (mem_wb_en & (m1_mem | m2_mem)));
    end
  end

  // Memory FSM state and latency counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory FSM next state and raw stall/done indications.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    done_raw  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          stall_raw = 1'b1;
          state_d   = S_ACCESS;
          cnt_d     = CNT_INIT;
        end
      end
      S_ACCESS: begin
        stall_raw = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        // A request still high here belongs to the completing instruction.
        done_raw = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Prioritised freeze/flush: memory stall, then branch, then hazard.
  always_comb begin
    freeze_pc    = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_exe = 1'b0;
    mem_stall    = 1'b0;
    mem_done     = 1'b0;
    hazard_stall = 1'b0;
    if (!rst) begin
      mem_stall = stall_raw;
      mem_done  = done_raw;
      if (stall_raw) begin
        freeze_pc = 1'b1;
      end else if (branch_taken) begin
        flush_if_id  = 1'b1;
        flush_id_exe = 1'b1;
      end else if (hazard) begin
        freeze_pc    = 1'b1;
        flush_id_exe = 1'b1;
        hazard_stall = 1'b1;
      end
    end
  end

  // Saturating count of cycles lost to hazard bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (hazard_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = rst ? '0 : stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Three instances share stimulus:
// u0 full RAW check (CNT_W=16), u1 load-use only (FWD_EN=1), u2 CNT_W=2.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [3:0] id_src1 = '0;
  logic [3:0] id_src2 = '0;
  logic       id_use_src1 = 1'b0;
  logic       id_two_src = 1'b0;
  logic [3:0] exe_dest = '0;
  logic       exe_wb_en = 1'b0;
  logic       exe_mem_r_en = 1'b0;
  logic [3:0] mem_dest = '0;
  logic       mem_wb_en = 1'b0;
  logic       branch_taken = 1'b0;
  logic       mem_req = 1'b0;

  logic        f0, fif0, fie0, ms0, md0;
  logic [15:0] sc0;
  logic        f1, fif1, fie1, ms1, md1;
  logic [15:0] sc1;
  logic        f2, fif2, fie2, ms2, md2;
  logic [1:0]  sc2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_LAT(4), .FWD_EN(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_two_src(id_two_src), .exe_dest(exe_dest),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest),
    .mem_wb_en(mem_wb_en), .branch_taken(branch_taken), .mem_req(mem_req),
    .freeze_pc(f0), .flush_if_id(fif0), .flush_id_exe(fie0), .mem_stall(ms0),
    .mem_done(md0), .stall_cnt(sc0));

  pipeline_hazard_ctrl #(.MEM_LAT(4), .FWD_EN(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_two_src(id_two_src), .exe_dest(exe_dest),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest),
    .mem_wb_en(mem_wb_en), .branch_taken(branch_taken), .mem_req(mem_req),
    .freeze_pc(f1), .flush_if_id(fif1), .flush_id_exe(fie1), .mem_stall(ms1),
    .mem_done(md1), .stall_cnt(sc1));

  pipeline_hazard_ctrl #(.MEM_LAT(4), .FWD_EN(0), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_two_src(id_two_src), .exe_dest(exe_dest),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest),
    .mem_wb_en(mem_wb_en), .branch_taken(branch_taken), .mem_req(mem_req),
    .freeze_pc(f2), .flush_if_id(fif2), .flush_id_exe(fie2), .mem_stall(ms2),
    .mem_done(md2), .stall_cnt(sc2));

  task automatic clear_inputs();
    id_valid = 1'b0; id_src1 = '0; id_src2 = '0; id_use_src1 = 1'b0; id_two_src = 1'b0;
    exe_dest = '0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_dest = '0; mem_wb_en = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0;
  endtask

  // Leaves the bench at a falling edge with rst released and the FSM idle.
  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // RAW on src1 against EXE (distinct register in MEM).
  task automatic set_exe_raw();
    id_valid = 1'b1; id_src1 = 4'd3; id_use_src1 = 1'b1;
    exe_dest = 4'd3; exe_wb_en = 1'b1; mem_dest = 4'd9;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    set_exe_raw();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; mem_req = 1'b1; branch_taken = 1'b1;
    #1;
    total++;
    if ({f0, fif0, fie0, ms0, md0} !== 5'b0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=00000", {f0, fif0, fie0, ms0, md0});
    end
    total++;
    if (sc0 !== 16'd0) begin
      bad++; $display("FAIL reset_cnt_comb got=%0d exp=0", sc0);
    end
    @(negedge clk);
    rst = 1'b0; clear_inputs();
    #1;
    total++;
    if (sc0 !== 16'd0 || ms0 !== 1'b0) begin
      bad++; $display("FAIL reset_next_state got cnt=%0d stall=%b exp cnt=0 stall=0", sc0, ms0);
    end
  endtask

  task automatic test_raw_nofwd();
    do_reset();
    set_exe_raw();
    #1;
    total++;
    if ({f0, fif0, fie0} !== 3'b101) begin
      bad++; $display("FAIL raw_exe got=%b exp=101", {f0, fif0, fie0});
    end
    total++;
    if (sc0 !== 16'd0) begin
      bad++; $display("FAIL raw_cnt_before got=%0d exp=0", sc0);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    total++;
    if (sc0 !== 16'd1) begin
      bad++; $display("FAIL raw_cnt_after got=%0d exp=1", sc0);
    end
    // Same match on the MEM destination, through src2.
    id_valid = 1'b1; id_src2 = 4'd7; id_two_src = 1'b1; mem_dest = 4'd7; mem_wb_en = 1'b1;
    exe_dest = 4'd2; exe_wb_en = 1'b1;
    #1;
    total++;
    if ({f0, fie0} !== 2'b11) begin
      bad++; $display("FAIL raw_mem got=%b exp=11", {f0, fie0});
    end
    mem_wb_en = 1'b0;
    #1;
    total++;
    if ({f0, fie0} !== 2'b00) begin
      bad++; $display("FAIL raw_wb_off got=%b exp=00", {f0, fie0});
    end
    mem_wb_en = 1'b1; id_valid = 1'b0;
    #1;
    total++;
    if (f0 !== 1'b0) begin
      bad++; $display("FAIL raw_invalid got=%b exp=0", f0);
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    set_exe_raw();
    #1;
    total++;
    if (f1 !== 1'b0) begin
      bad++; $display("FAIL fwd_no_load got=%b exp=0", f1);
    end
    exe_mem_r_en = 1'b1;
    #1;
    total++;
    if ({f1, fif1, fie1} !== 3'b101) begin
      bad++; $display("FAIL fwd_load_use got=%b exp=101", {f1, fif1, fie1});
    end
    // MEM-stage match is bypassed when forwarding exists.
    exe_mem_r_en = 1'b0; exe_dest = 4'd1; mem_dest = 4'd3; mem_wb_en = 1'b1;
    #1;
    total++;
    if (f1 !== 1'b0 || f0 !== 1'b1) begin
      bad++; $display("FAIL fwd_mem_match got u1=%b u0=%b exp u1=0 u0=1", f1, f0);
    end
    clear_inputs();
  endtask

  task automatic test_mem_latency();
    do_reset();
    mem_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      total++;
      if (ms0 !== (k != 4 && k != 9) || md0 !== (k == 4 || k == 9) || f0 !== ms0) begin
        bad++; $display("FAIL mem_seq k=%0d got stall=%b done=%b freeze=%b exp stall=%b done=%b",
                        k, ms0, md0, f0, (k != 4 && k != 9), (k == 4 || k == 9));
      end
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem_req = 1'b1; branch_taken = 1'b1; set_exe_raw();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 4) mem_req = 1'b0;
      #1;
      total++;
      if (k < 4 && {f0, fif0, fie0} !== 3'b100) begin
        bad++; $display("FAIL br_during_stall k=%0d got=%b exp=100", k, {f0, fif0, fie0});
      end else if (k == 4 && {f0, fif0, fie0, md0} !== 4'b0111) begin
        bad++; $display("FAIL br_done_cycle got=%b exp=0111", {f0, fif0, fie0, md0});
      end
    end
    @(negedge clk);
    #1;
    total++;
    if ({f0, fif0, fie0} !== 3'b011) begin
      bad++; $display("FAIL br_over_hazard got=%b exp=011", {f0, fif0, fie0});
    end
    total++;
    if (sc0 !== 16'd0) begin
      bad++; $display("FAIL br_no_count got=%0d exp=0", sc0);
    end
    clear_inputs();
  endtask

  task automatic test_reset_abort();
    do_reset();
    mem_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; mem_req = 1'b0;
    #1;
    total++;
    if ({ms0, f0, md0} !== 3'b000) begin
      bad++; $display("FAIL abort_in_rst got=%b exp=000", {ms0, f0, md0});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (ms0 !== 1'b0 || md0 !== 1'b0) begin
        bad++; $display("FAIL abort_after k=%0d got stall=%b done=%b exp 0 0", k, ms0, md0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    set_exe_raw();
    repeat (5) @(negedge clk);
    clear_inputs();
    #1;
    total++;
    if (sc2 !== 2'd3) begin
      bad++; $display("FAIL sat_cnt2 got=%0d exp=3", sc2);
    end
    total++;
    if (sc0 !== 16'd5) begin
      bad++; $display("FAIL sat_cnt16 got=%0d exp=5", sc0);
    end
  endtask

  initial begin
    test_reset();
    test_raw_nofwd();
    test_load_use();
    test_mem_latency();
    test_back_to_back();
    test_reset_abort();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
